// File: rtl/univ_sh_rgst.sv
// Universal shift register: parallel load, single-step shifts in three fill modes,
// and a multi-cycle "shift N times" command with busy/done status.
module univ_sh_rgst #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    input  logic             ld,
    input  logic             sh,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             sh_in,
    input  logic             start,
    input  logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] q,
    output logic             sh_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
    // busy stays high for exactly cnt edges, then done is high for one cycle.
    // ld/sh/start presented while busy=1 are dropped, not queued.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic           dir_l;
    logic [1:0]     mode_l;
    logic [CW-1:0]  rem;

    // Returns {bit shifted out, next register value} for one step.
    function automatic logic [WIDTH:0] step(
        input logic [WIDTH-1:0] cur,
        input logic             sdir,
        input logic [1:0]       smode,
        input logic             sin
    );
        logic fill;
        if (!sdir) begin
            case (smode)
                2'b01:   fill = 1'b0;
                2'b10:   fill = cur[WIDTH-1];
                default: fill = sin;
            endcase
            step = {cur[WIDTH-1], cur[WIDTH-2:0], fill};
        end else begin
            case (smode)
                2'b01:   fill = cur[WIDTH-1];
                2'b10:   fill = cur[0];
                default: fill = sin;
            endcase
            step = {cur[0], fill, cur[WIDTH-1:1]};
        end
    endfunction

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= IDLE;
            q      <= '0;
            sh_out <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dir_l  <= 1'b0;
            mode_l <= 2'b00;
            rem    <= '0;
        end else begin
            case (state)
                RUN: begin
                    {sh_out, q} <= step(q, dir_l, mode_l, sh_in);
                    rem         <= rem - 1'b1;
                    if (rem == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        dir_l  <= dir;
                        mode_l <= mode;
                        rem    <= cnt;
                        if (cnt == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        if (ld) begin
                            q <= d;
                        end else if (sh) begin
                            {sh_out, q} <= step(q, dir, mode, sh_in);
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/univ_sh_rgst.md
# univ_sh_rgst

Parametrised universal shift register that replaces the fixed 16-bit load/shift-left register. It adds configurable width, shift direction, three fill modes (logical, arithmetic, rotate) and a registered serial output. It also adds a multi-cycle "shift N times" command with busy/done handshake. It sits in the datapath wherever operands need serial conversion, scaling by powers of two or bit rotation.

## Interface
- WIDTH, 16, register width in bits (≥ 2)
- CW, $clog2(WIDTH+1), width of the shift-count input
- clk  input  1  clock; all state updates on the rising edge
- rst_b  input  1  asynchronous, active-low reset
- d  input  WIDTH  parallel load data
- ld  input  1  parallel load request
- sh  input  1  single-step shift request
- dir  input  1  0 = shift left (toward MSB), 1 = shift right
- mode  input  2  00 logical (fill from sh_in), 01 arithmetic, 10 rotate, 11 same as 00
- sh_in  input  1  serial fill bit in logical mode
- start  input  1  launch a multi-cycle shift of cnt steps
- cnt  input  CW  number of steps for start
- q  output  WIDTH  register contents
- sh_out  output  1  last bit shifted out (registered)
- busy  output  1  multi-cycle shift in progress
- done  output  1  one-cycle completion pulse

## Operation
- One shift step with dir=0:
  - Logical: q ← {q[W-2:0], sh_in}.
  - Arithmetic: fill is 0.
  - Rotate: fill is q[W-1].
  - sh_out ← q[W-1] (value before the step).
- One shift step with dir=1:
  - Logical: q ← {sh_in, q[W-1:1]}.
  - Arithmetic: fill is q[W-1] (sign preserved).
  - Rotate: fill is q[0].
  - sh_out ← q[0].
- FSM states:
  - IDLE: accepts commands.
  - RUN: multi-cycle shift in progress.
  - DONE: accepts commands exactly as IDLE does; done=1.
- Command priority in IDLE/DONE: start > ld > sh > hold.
  - ld: q ← d; sh_out unchanged.
  - sh: one step using the current dir/mode/sh_in.
- start: dir, mode and cnt are latched into internal registers; q is not modified on the accepting edge.
  - cnt=0: next state is DONE.
  - cnt≠0: next state is RUN with rem=cnt.
- RUN, each edge:
  - One step using the latched dir/mode and the live sh_in; rem decrements.
  - When rem reaches 0, next state is DONE.
  - ld, sh and start are ignored in RUN.
- DONE with no new command: the next edge returns to IDLE.
- busy=1 exactly in RUN; done=1 exactly in DONE.
- Reset (any time, including mid-RUN): q=0, sh_out=0, busy=0, done=0, state=IDLE, rem=0. Takes effect immediately, without waiting for a clock edge.
- cnt > WIDTH is legal:
  - Rotate wraps.
  - Logical/arithmetic simply keep filling.

## Timing
- ld/sh: result visible after the same rising edge where the request is sampled (latency 1).
- start sampled at edge k with cnt=N>0:
  - busy high after edge k.
  - Shifts occur at edges k+1 … k+N.
  - After edge k+N: busy=0, done=1.
  - After edge k+N+1: done=0, unless a new start produces DONE again.
- start with cnt=0 at edge k: done=1 after edge k for one cycle; busy never rises.
- A start sampled while done=1 is accepted, so back-to-back runs have no idle gap.
- Inputs must be stable around the rising edge. Behaviour for changes exactly at the edge is undefined.

## Test plan
- Reset: rst_b=0 from t=0, released at t=25 with CLK_PERIOD=100 → q=0000, sh_out=0, busy=0, done=0. Asserting rst_b=0 mid-RUN clears all outputs immediately, without waiting for a clock edge.
- Load priority: ld=1, sh=1, d=16'hAB00 at one edge → q=AB00 (load wins), sh_out unchanged.
- Logical left: q=AB00, sh=1, dir=0, mode=00, sh_in=1 → q=5601, sh_out=1. Next step with sh_in=0 → q=AC02, sh_out=0.
- Arithmetic right: q=8001, sh=1, dir=1, mode=01 → q=C000, sh_out=1. Second step → q=E000, sh_out=0.
- Multi-cycle rotate: q=1234, start=1, cnt=4, dir=1, mode=10:
  - busy high for 4 cycles; ld=1 with d=FFFF during busy is ignored.
  - Final q=4123, sh_out=0.
  - done pulses for exactly 1 cycle, then returns low.
- Zero count and back-to-back:
  - start with cnt=0 → done=1 the next cycle, q unchanged, busy stays 0.
  - start with cnt=2 (dir=0, mode=10) issued during that done cycle on q=8001 → after 2 steps q=0006; a second done pulse follows.
